// File: rtl/simon_input_checker.sv
// simon_input_checker: judges the player's presses against the latched Simon
// sequence. One press per slot, a release between presses, and an inactivity
// timeout on every wait. Emits a one-cycle round_ok/fail pulse, a saturating
// score, and an echo of the accepted button for the LEDs.
module simon_input_checker #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  num_colours_generated,
    input  logic [49:0] colours_generated,
    input  logic [4:0]  buttons,
    output logic        busy,
    output logic        round_ok,
    output logic        fail,
    output logic [3:0]  index,
    output logic [3:0]  score,
    output logic [4:0]  echo
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_PRESS, S_WAIT_RELEASE, S_DONE_OK, S_DONE_FAIL
    } state_t;

    localparam logic [25:0] TMAX = 26'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_n;
    logic        r_start_prev;
    logic [49:0] r_seq,   w_seq_n;
    logic [3:0]  r_n,     w_n_n;
    logic [3:0]  r_index, w_index_n;
    logic [25:0] r_timer, w_timer_n;
    logic [4:0]  r_echo,  w_echo_n;
    logic [3:0]  r_score, w_score_n;
    logic        r_ok,    w_ok_n;
    logic        r_fail,  w_fail_n;
    logic        r_busy,  w_busy_n;

    logic [4:0]  w_slot;
    logic        w_onehot, w_start_edge, w_timeout, w_go_ok, w_go_fail;
    logic [3:0]  w_n_clamped, w_score_inc;

    assign w_start_edge = start & ~r_start_prev;
    assign w_onehot     = (buttons != 5'd0) && ((buttons & (buttons - 5'd1)) == 5'd0);
    assign w_n_clamped  = (num_colours_generated > 4'd10) ? 4'd10 : num_colours_generated;
    assign w_timeout    = (r_timer == TMAX);
    assign w_score_inc  = (r_score == 4'd15) ? 4'd15 : r_score + 4'd1;

    // Select the colour expected at the current slot from the latched sequence.
    always_comb begin
        w_slot = 5'd0;
        for (int k = 0; k < 10; k++)
            if (r_index == 4'(k)) w_slot = r_seq[5*k +: 5];
    end

    // Next-state and next-output logic; DONE entries share one set of actions.
    always_comb begin
        w_state_n = r_state;
        w_seq_n   = r_seq;
        w_n_n     = r_n;
        w_index_n = r_index;
        w_timer_n = r_timer;
        w_echo_n  = r_echo;
        w_score_n = r_score;
        w_ok_n    = 1'b0;
        w_fail_n  = 1'b0;
        w_busy_n  = r_busy;
        w_go_ok   = 1'b0;
        w_go_fail = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_seq_n   = colours_generated;
                    w_n_n     = w_n_clamped;
                    w_index_n = 4'd0;
                    w_timer_n = 26'd0;
                    w_busy_n  = 1'b1;
                    if (w_n_clamped == 4'd0) w_go_ok = 1'b1;
                    else                     w_state_n = S_ARM;
                end
            end
            S_ARM: begin
                // A press held over from playback must be released first.
                if (buttons == 5'd0) begin
                    w_timer_n = 26'd0;
                    w_state_n = S_WAIT_PRESS;
                end else if (w_timeout) w_go_fail = 1'b1;
                else                    w_timer_n = r_timer + 26'd1;
            end
            S_WAIT_PRESS: begin
                if (buttons == 5'd0) begin
                    if (w_timeout) w_go_fail = 1'b1;
                    else           w_timer_n = r_timer + 26'd1;
                end else if (w_onehot && buttons == w_slot) begin
                    w_echo_n  = buttons;
                    w_timer_n = 26'd0;
                    w_state_n = S_WAIT_RELEASE;
                end else w_go_fail = 1'b1;
            end
            S_WAIT_RELEASE: begin
                if (buttons == 5'd0) begin
                    w_echo_n  = 5'd0;
                    w_timer_n = 26'd0;
                    if (r_index == r_n - 4'd1) w_go_ok = 1'b1;
                    else begin
                        w_index_n = r_index + 4'd1;
                        w_state_n = S_WAIT_PRESS;
                    end
                end else if (buttons != r_echo || w_timeout) w_go_fail = 1'b1;
                else w_timer_n = r_timer + 26'd1;
            end
            S_DONE_OK, S_DONE_FAIL: begin
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_go_ok) begin
            w_state_n = S_DONE_OK;
            w_ok_n    = 1'b1;
            w_score_n = w_score_inc;
        end
        if (w_go_fail) begin
            w_state_n = S_DONE_FAIL;
            w_fail_n  = 1'b1;
            w_score_n = 4'd0;
            w_echo_n  = 5'd0;
            w_timer_n = 26'd0;
        end
    end

    // State and output registers; reset clears everything without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b0;
            r_seq        <= 50'd0;
            r_n          <= 4'd0;
            r_index      <= 4'd0;
            r_timer      <= 26'd0;
            r_echo       <= 5'd0;
            r_score      <= 4'd0;
            r_ok         <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_start_prev <= start;
            r_seq        <= w_seq_n;
            r_n          <= w_n_n;
            r_index      <= w_index_n;
            r_timer      <= w_timer_n;
            r_echo       <= w_echo_n;
            r_score      <= w_score_n;
            r_ok         <= w_ok_n;
            r_fail       <= w_fail_n;
            r_busy       <= w_busy_n;
        end
    end

    assign busy     = r_busy;
    assign round_ok = r_ok;
    assign fail     = r_fail;
    assign index    = r_index;
    assign score    = r_score;
    assign echo     = r_echo;

endmodule

// File: tb/tb_simon_input_checker.sv
// Bench for simon_input_checker with a short timeout. Expected round results
// are queued when a round is launched and compared when a pulse appears.
module tb_simon_input_checker;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  num;
    logic [49:0] cols;
    logic [4:0]  buttons;
    logic        busy, round_ok, fail;
    logic [3:0]  index, score;
    logic [4:0]  echo;

    int checks = 0;
    int errors = 0;
    int mscore = 0;

    typedef struct { bit is_ok; int sc; } exp_t;
    exp_t exp_q[$];

    simon_input_checker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_colours_generated(num), .colours_generated(cols), .buttons(buttons),
        .busy(busy), .round_ok(round_ok), .fail(fail),
        .index(index), .score(score), .echo(echo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    function automatic logic [49:0] rand_seq;
        logic [49:0] c;
        logic [4:0]  one;
        c = '0;
        for (int k = 0; k < 10; k++) begin
            one = 5'd1 << $urandom_range(0, 4);
            c[5*k +: 5] = one;
        end
        return c;
    endfunction

    task automatic expect_ok;
        exp_t e;
        mscore = (mscore >= 15) ? 15 : mscore + 1;
        e.is_ok = 1'b1; e.sc = mscore;
        exp_q.push_back(e);
    endtask

    task automatic expect_fail;
        exp_t e;
        mscore = 0;
        e.is_ok = 1'b0; e.sc = 0;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [3:0] n, input logic [49:0] c, input string name);
        num = n; cols = c; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy: got %b want 1", name, busy);
        end
    endtask

    // Plays n correct press/release pairs; the first tick lets ARM pass.
    task automatic play(input int n, input logic [49:0] c, input string name);
        logic [4:0] s;
        tick;
        for (int k = 0; k < n; k++) begin
            s = c[5*k +: 5];
            checks++;
            if (index !== 4'(k)) begin
                errors++; $display("FAIL %s_index%0d: got %0d want %0d", name, k, index, k);
            end
            buttons = s;
            tick;
            checks++;
            if (echo !== s || round_ok !== 1'b0 || fail !== 1'b0) begin
                errors++; $display("FAIL %s_echo%0d: got echo=%b ok=%b fail=%b want echo=%b", name, k, echo, round_ok, fail, s);
            end
            buttons = 5'd0;
            tick;
            if (k < n - 1) begin
                checks++;
                if (echo !== 5'd0 || busy !== 1'b1) begin
                    errors++; $display("FAIL %s_rel%0d: got echo=%b busy=%b want 0/1", name, k, echo, busy);
                end
            end
        end
    endtask

    task automatic wait_result(input string name, input int budget);
        exp_t e;
        int   n;
        bit   got;
        got = 1'b0; n = 0;
        while (!got && n <= budget) begin
            if (round_ok || fail) got = 1'b1;
            else begin tick; n++; end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s: no pulse within %0d cycles", name, budget);
        end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s: unexpected pulse ok=%b fail=%b", name, round_ok, fail);
        end else begin
            e = exp_q.pop_front();
            if (round_ok !== e.is_ok || fail !== !e.is_ok) begin
                errors++; $display("FAIL %s_kind: got ok=%b fail=%b want ok=%b", name, round_ok, fail, e.is_ok);
            end
            checks++;
            if (score !== 4'(e.sc)) begin
                errors++; $display("FAIL %s_score: got %0d want %0d", name, score, e.sc);
            end
            tick;
            checks++;
            if (round_ok !== 1'b0 || fail !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL %s_after: got ok=%b fail=%b busy=%b want 0/0/0", name, round_ok, fail, busy);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; num = '0; cols = '0; buttons = '0;
        tick; tick;
        checks++;
        if ({busy, round_ok, fail, index, score, echo} !== 16'd0) begin
            errors++; $display("FAIL reset: got busy=%b ok=%b fail=%b idx=%0d score=%0d echo=%b want all 0", busy, round_ok, fail, index, score, echo);
        end
        @(negedge clk); rst = 1'b0;
        tick;
    endtask

    task automatic test_round_n3;
        logic [49:0] c;
        c = '0;
        c[4:0] = 5'b00100; c[9:5] = 5'b01000; c[14:10] = 5'b00001;
        do_start(4'd3, c, "n3");
        expect_ok;
        play(3, c, "n3");
        wait_result("n3", 0);
    endtask

    task automatic test_wrong;
        logic [49:0] c;
        c = rand_seq();
        c[4:0] = 5'b00100; c[9:5] = 5'b00010;
        do_start(4'd4, c, "wrong");
        expect_fail;
        tick;
        buttons = 5'b00100; tick;
        buttons = 5'd0;     tick;
        checks++;
        if (index !== 4'd1) begin
            errors++; $display("FAIL wrong_index: got %0d want 1", index);
        end
        buttons = 5'b01000; tick;
        wait_result("wrong", 0);
        buttons = 5'd0;
    endtask

    task automatic test_timeout;
        logic [49:0] c;
        c = rand_seq();
        do_start(4'd2, c, "to_idle");
        expect_fail;
        tick;
        repeat (TO - 1) tick;
        checks++;
        if (fail !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_idle_early: got fail=%b busy=%b want 0/1", fail, busy);
        end
        tick;
        wait_result("to_idle", 0);
        do_start(4'd2, c, "to_hold");
        expect_fail;
        tick;
        buttons = c[4:0]; tick;
        repeat (TO - 1) tick;
        checks++;
        if (fail !== 1'b0 || echo !== c[4:0]) begin
            errors++; $display("FAIL to_hold_early: got fail=%b echo=%b want 0/%b", fail, echo, c[4:0]);
        end
        tick;
        wait_result("to_hold", 0);
        buttons = 5'd0;
    endtask

    task automatic test_multi;
        logic [49:0] c;
        c = rand_seq();
        do_start(4'd3, c, "multi");
        expect_fail;
        tick;
        buttons = 5'b00101; tick;
        wait_result("multi", 0);
        buttons = 5'd0;
    endtask

    task automatic test_held_across_start;
        logic [49:0] c;
        c = rand_seq();
        buttons = c[4:0];
        do_start(4'd3, c, "held");
        repeat (5) tick;
        checks++;
        if (busy !== 1'b1 || echo !== 5'd0 || fail !== 1'b0 || index !== 4'd0) begin
            errors++; $display("FAIL held_arm: got busy=%b echo=%b fail=%b idx=%0d want 1/0/0/0", busy, echo, fail, index);
        end
        buttons = 5'd0;
        expect_ok;
        play(3, c, "held");
        wait_result("held", 0);
    endtask

    task automatic test_reset_mid;
        logic [49:0] c;
        c = rand_seq();
        c[4:0] = 5'b00001; c[9:5] = 5'b00010;
        do_start(4'd2, c, "rmid");
        tick;
        buttons = 5'b00001; tick;
        buttons = 5'd0;     tick;
        start = 1'b1; tick;
        start = 1'b0; tick;
        checks++;
        if (index !== 4'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_start_ignored: got idx=%0d busy=%b want 1/1", index, busy);
        end
        buttons = 5'b00010; tick;
        checks++;
        if (echo !== 5'b00010) begin
            errors++; $display("FAIL rmid_echo: got %b want 00010", echo);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, round_ok, fail, index, score, echo} !== 16'd0) begin
            errors++; $display("FAIL rmid_reset: got busy=%b ok=%b fail=%b idx=%0d score=%0d echo=%b want all 0", busy, round_ok, fail, index, score, echo);
        end
        mscore = 0;
        buttons = 5'd0;
        tick;
        @(negedge clk); rst = 1'b0;
        tick;
        checks++;
        if (round_ok !== 1'b0 || fail !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_nopulse: got ok=%b fail=%b busy=%b want 0/0/0", round_ok, fail, busy);
        end
    endtask

    task automatic test_n0;
        do_start(4'd0, rand_seq(), "n0");
        expect_ok;
        wait_result("n0", 0);
    endtask

    task automatic test_n12;
        logic [49:0] c;
        c = rand_seq();
        do_start(4'd12, c, "n12");
        expect_ok;
        play(10, c, "n12");
        wait_result("n12", 0);
    endtask

    task automatic test_saturate;
        logic [49:0] c;
        for (int r = 0; r < 16; r++) begin
            c = rand_seq();
            do_start(4'd1, c, "sat");
            expect_ok;
            play(1, c, "sat");
            wait_result("sat", 2);
        end
        checks++;
        if (score !== 4'd15) begin
            errors++; $display("FAIL sat_final: got %0d want 15", score);
        end
    endtask

    initial begin
        test_reset;
        test_round_n3;
        test_wrong;
        test_timeout;
        test_multi;
        test_held_across_start;
        test_reset_mid;
        test_n0;
        test_n12;
        test_saturate;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover: %0d expected results never seen", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/simon_input_checker.md
# simon_input_checker

Checks the player's button presses against the stored Simon colour sequence once playback finishes. It sits downstream of the sequence player and sequence storage. It latches the sequence and its length at start, then steps through the slots one press at a time, with an inactivity timeout. It reports a one-cycle round-complete or fail pulse, a running score, and an echo of the accepted button for the LEDs.

## Interface
- TIMEOUT_CYCLES, 50_000_000: idle cycles allowed per step (1 s at 50 MHz); counter 26 bits.
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  rising edge begins a check; driven by the sequence player's doneplaying.
- num_colours_generated  in  4  sequence length N; valid 0..10; values >10 treated as 10.
- colours_generated  in  50  slot k at [5k+4:5k], one-hot colour.
- buttons  in  5  synchronised, debounced, active-high; bit0 blue, bit1 yellow, bit2 red, bit3 green, bit4 orange.
- busy  out  1  high while a check is in progress.
- round_ok  out  1  one-cycle pulse: all N slots matched.
- fail  out  1  one-cycle pulse: wrong, multi-button, or timed-out press.
- index  out  4  slot currently expected (0..9).
- score  out  4  consecutive successful rounds, saturating at 15.
- echo  out  5  accepted press, held while the button is down; 0 otherwise.

## Operation
- Reset values: all outputs 0, state IDLE, timer 0, latched sequence 0, start-edge register 0.
- Start detect: internal registered copy of start; edge = start & ~prev. If start is already high when rst releases, it counts as an edge on the first clock.
- IDLE: on a start edge, latch colours_generated and clamped N, clear index and timer, set busy.
  - If N==0: go to DONE_OK.
  - Otherwise: go to ARM.
- ARM: wait for buttons==0 so a press held across playback is not counted, then go to WAIT_PRESS. Timer runs; timeout leads to DONE_FAIL.
- WAIT_PRESS:
  - buttons==0: timer increments; when timer reaches TIMEOUT_CYCLES-1, go to DONE_FAIL.
  - buttons!=0, not one-hot: DONE_FAIL.
  - buttons!=0, one-hot, not equal to latched slot[index]: DONE_FAIL.
  - buttons equal to slot[index]: echo<=buttons, timer<=0, go to WAIT_RELEASE.
- WAIT_RELEASE:
  - While buttons!=0, hold; timer runs with the same timeout, so a stuck button fails.
  - A change to a different nonzero pattern while held is a fail.
  - On buttons==0: echo<=0, timer<=0.
    - If index==N-1: go to DONE_OK.
    - Else: index<=index+1, go to WAIT_PRESS.
- DONE_OK: round_ok=1, score<=min(score+1,15); next edge returns to IDLE.
- DONE_FAIL: fail=1, score<=0, echo<=0; next edge returns to IDLE.
- Start edges while busy are ignored. The latched sequence does not track input changes during a check.
- index stays at its last value in IDLE; it clears on the next start.

## Timing
- All outputs are registered.
- Decision latency is 1 cycle: buttons sampled at edge E produce the state change, echo, and pulse from edge E.
- busy rises at the edge that accepts start. It falls at the edge that leaves DONE_OK/DONE_FAIL, which is the same edge the pulse drops.
- round_ok and fail are each high for exactly one cycle and are never high together.
- The timeout fires on the TIMEOUT_CYCLES-th consecutive waiting cycle. Any accepted press or release clears the timer.
- Async rst mid-check: immediate return to reset values. No pulse is emitted.

## Test plan
- N=3, slots {red,green,blue}: press/release 00100, 01000, 00001 -> echo follows each press; index 0,1,2; round_ok for 1 cycle; score 0->1; busy low after.
- N=4, slot1=yellow: press correct slot0, then press 01000 -> fail pulse at the edge after sampling; score cleared to 0; no round_ok.
- TIMEOUT_CYCLES=8, N=2: start with no presses -> fail exactly 8 cycles after entering WAIT_PRESS; also hold a correct button 8 cycles -> fail.
- Buttons 00101 pressed at slot0 -> fail. Buttons held high across start -> stays in ARM, no judgement until release.
- Assert rst while in WAIT_RELEASE with echo=00010 -> echo, busy, index, and score all 0 immediately. Start pulses during busy are ignored.
- N=0 -> round_ok the cycle after start. N=12 -> behaves as 10. Sixteen successful rounds -> score saturates at 15.
